cfeb_busy_sequencer: RTL and testbench

- Controls the per-CFEB busy inputs of the best-1-of-7 1/2-strip pattern sorter and registers its winning pattern as the output.
- When a CFEB wins, it is blanked for a programmable dead time so it cannot win again immediately. The neighbouring CFEBs can optionally be blanked as well.
- Sits directly after the 7-CFEB sorter in the pattern-finder pipeline and feeds the LCT builder.

---
 rtl/cfeb_busy_sequencer_pkg.sv | 35 +++
 rtl/cfeb_busy_sequencer_dead_timer.sv | 49 ++++
 rtl/cfeb_busy_sequencer.sv | 106 ++++++++++
 tb/tb_cfeb_busy_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfeb_busy_sequencer_pkg.sv
// Shared constants, field positions and helpers for the CFEB busy sequencer.
package cfeb_busy_sequencer_pkg;

   localparam int unsigned MXCFEB  = 7;
   localparam int unsigned MXPATB  = 7;
   localparam int unsigned MXKEYBX = 8;
   localparam int unsigned MXDTB   = 4;

   // Pattern field: hit count in the top three bits
   localparam int unsigned HIT_MSB = 6;
   localparam int unsigned HIT_LSB = 4;

   // Key field: CFEB index in the top three bits
   localparam int unsigned CFEB_MSB = 7;
   localparam int unsigned CFEB_LSB = 5;

   // Index value that does not correspond to any CFEB
   localparam logic [2:0] CFEB_BAD = 3'd7;

   // Per-CFEB dead timer states
   typedef enum logic {
      DT_IDLE = 1'b0,
      DT_DEAD = 1'b1
   } dt_state_t;

   // True when CFEB i is the winner or, with spreading, an adjacent CFEB.
   function automatic logic is_target(input logic [2:0] w, input int unsigned i, input logic spread);
      logic [3:0] wx;
      logic [3:0] ix;
      wx = {1'b0, w};
      ix = 4'(i);
      return (wx == ix) | (spread & ((wx + 4'd1 == ix) | (ix + 4'd1 == wx)));
   endfunction

endpackage

// File: rtl/cfeb_busy_sequencer_dead_timer.sv
// Per-CFEB blanking timer: loads the longer of the running count and the new
// dead time, otherwise counts down to zero.
module cfeb_dead_timer
   import cfeb_busy_sequencer_pkg::*;
#(
   parameter int unsigned DTB = MXDTB
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  logic [DTB-1:0] dead_time,
   output logic [DTB-1:0] dcnt
);

   dt_state_t state;

   // Two-state timer; state DT_DEAD always coincides with a non-zero count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= DT_IDLE;
         dcnt  <= '0;
      end else begin
         case (state)
            DT_IDLE: begin
               if (load && (dead_time != '0)) begin
                  state <= DT_DEAD;
                  dcnt  <= dead_time;
               end
            end
            DT_DEAD: begin
               if (load) begin
                  // a reload never shortens a running count
                  if (dead_time > dcnt) dcnt <= dead_time;
               end else if (dcnt == DTB'(1)) begin
                  state <= DT_IDLE;
                  dcnt  <= '0;
               end else begin
                  dcnt  <= dcnt - DTB'(1);
               end
            end
            default: begin
               state <= DT_IDLE;
               dcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cfeb_busy_sequencer.sv
// Busy sequencer behind the best-1-of-7 CFEB pattern sorter: accepts the
// sorter's winner, registers it for the LCT builder, and blanks the winning
// (and optionally neighbouring) CFEBs for a programmable dead time.
module cfeb_busy_sequencer
   import cfeb_busy_sequencer_pkg::*;
#(
   parameter int unsigned DTB    = MXDTB,
   parameter int unsigned MXCNTB = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [MXCFEB-1:0]  cfeb_en,
   input  logic [DTB-1:0]     dead_time,
   input  logic [2:0]         hit_thresh,
   input  logic               spread_en,
   input  logic               cnt_clr,
   input  logic [MXPATB-1:0]  best_pat,
   input  logic [MXKEYBX-1:0] best_key,
   input  logic               best_bsy,
   output logic [MXCFEB-1:0]  bsy,
   output logic               lct_vld,
   output logic [MXPATB-1:0]  lct_pat,
   output logic [MXKEYBX-1:0] lct_key,
   output logic [MXCNTB-1:0]  acc_cnt,
   output logic               key_err
);

   logic [2:0]        hits;
   logic [2:0]        w;
   logic              cand;
   logic              key_bad;
   logic              accept;
   logic [MXCFEB-1:0] load;
   logic [DTB-1:0]    dcnt [MXCFEB];

   // Accept decode from the sorter's winner
   always_comb begin
      hits    = best_pat[HIT_MSB:HIT_LSB];
      w       = best_key[CFEB_MSB:CFEB_LSB];
      cand    = ~best_bsy & (hits != '0) & (hits >= hit_thresh);
      key_bad = cand & (w == CFEB_BAD);
      accept  = cand & ~key_bad;
   end

   // Dead-timer load decode for the winner and its neighbours
   always_comb begin
      load = '0;
      for (int unsigned i = 0; i < MXCFEB; i++) begin
         load[i] = accept & is_target(w, i, spread_en);
      end
   end

   for (genvar g = 0; g < MXCFEB; g++) begin : g_dt
      cfeb_dead_timer #(.DTB(DTB)) u_dt (
         .clock     (clock),
         .reset     (reset),
         .load      (load[g]),
         .dead_time (dead_time),
         .dcnt      (dcnt[g])
      );
   end

   // Busy back to the sorter depends only on registers and enables
   always_comb begin
      bsy = '0;
      for (int unsigned i = 0; i < MXCFEB; i++) begin
         bsy[i] = ~cfeb_en[i] | (dcnt[i] != '0);
      end
   end

   // Registered accept strobe and captured pattern/key
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lct_vld <= 1'b0;
         lct_pat <= '0;
         lct_key <= '0;
      end else begin
         lct_vld <= accept;
         if (accept) begin
            lct_pat <= best_pat;
            lct_key <= best_key;
         end
      end
   end

   // Saturating accept counter, clear has priority
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_cnt <= '0;
      end else if (cnt_clr) begin
         acc_cnt <= '0;
      end else if (accept && (acc_cnt != '1)) begin
         acc_cnt <= acc_cnt + MXCNTB'(1);
      end
   end

   // Sticky invalid-index flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_err <= 1'b0;
      end else if (key_bad) begin
         key_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cfeb_busy_sequencer.sv
// Randomized and directed bench for cfeb_busy_sequencer against a
// timestamp-based reference model.
module tb_cfeb_busy_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  cfeb_en;
   logic [3:0]  dead_time;
   logic [2:0]  hit_thresh;
   logic        spread_en;
   logic        cnt_clr;
   logic [6:0]  best_pat;
   logic [7:0]  best_key;
   logic        best_bsy;

   logic [6:0]  bsy;
   logic        lct_vld;
   logic [6:0]  lct_pat;
   logic [7:0]  lct_key;
   logic [15:0] acc_cnt;
   logic        key_err;

   logic [6:0]  sat_bsy;
   logic        sat_vld;
   logic [6:0]  sat_pat;
   logic [7:0]  sat_key;
   logic [3:0]  sat_cnt;
   logic        sat_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   cfeb_busy_sequencer dut (
      .clock(clock), .reset(reset), .cfeb_en(cfeb_en), .dead_time(dead_time),
      .hit_thresh(hit_thresh), .spread_en(spread_en), .cnt_clr(cnt_clr),
      .best_pat(best_pat), .best_key(best_key), .best_bsy(best_bsy),
      .bsy(bsy), .lct_vld(lct_vld), .lct_pat(lct_pat), .lct_key(lct_key),
      .acc_cnt(acc_cnt), .key_err(key_err)
   );

   // Narrow counter instance so saturation is reachable quickly
   cfeb_busy_sequencer #(.MXCNTB(4)) dut_sat (
      .clock(clock), .reset(reset), .cfeb_en(cfeb_en), .dead_time(dead_time),
      .hit_thresh(hit_thresh), .spread_en(spread_en), .cnt_clr(cnt_clr),
      .best_pat(best_pat), .best_key(best_key), .best_bsy(best_bsy),
      .bsy(sat_bsy), .lct_vld(sat_vld), .lct_pat(sat_pat), .lct_key(sat_key),
      .acc_cnt(sat_cnt), .key_err(sat_err)
   );

   // Reference model: each CFEB is blanked until edge number busy_end[i]
   int        edge_n = 0;
   int        busy_end [7];
   logic      m_vld;
   logic [6:0] m_pat;
   logic [7:0] m_key;
   int        m_cnt;
   int        m_cnt_sat;
   logic      m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 7; i++) busy_end[i] = 0;
      m_vld = 1'b0; m_pat = '0; m_key = '0;
      m_cnt = 0; m_cnt_sat = 0; m_err = 1'b0;
   endtask

   task automatic model_edge();
      int  hit, w, rem, tmax;
      bit  cand, acc, tgt;
      edge_n++;
      hit  = int'(best_pat[6:4]);
      w    = int'(best_key[7:5]);
      cand = !best_bsy && hit != 0 && hit >= int'(hit_thresh);
      acc  = cand && w != 7;
      if (cand && w == 7) m_err = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tgt = (i == w) || (spread_en && (i == w - 1 || i == w + 1));
         if (acc && tgt) begin
            rem  = busy_end[i] > edge_n - 1 ? busy_end[i] - (edge_n - 1) : 0;
            tmax = rem > int'(dead_time) ? rem : int'(dead_time);
            busy_end[i] = edge_n + tmax;
         end
      end
      m_vld = acc;
      if (acc) begin
         m_pat = best_pat;
         m_key = best_key;
      end
      if (cnt_clr) begin
         m_cnt = 0; m_cnt_sat = 0;
      end else if (acc) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_sat < 15) m_cnt_sat++;
      end
   endtask

   function automatic logic [6:0] model_bsy();
      logic [6:0] b;
      for (int i = 0; i < 7; i++) b[i] = !cfeb_en[i] || (busy_end[i] > edge_n);
      return b;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, ".bsy"},     32'(bsy),     32'(model_bsy()));
      check({tag, ".vld"},     32'(lct_vld), 32'(m_vld));
      check({tag, ".pat"},     32'(lct_pat), 32'(m_pat));
      check({tag, ".key"},     32'(lct_key), 32'(m_key));
      check({tag, ".cnt"},     32'(acc_cnt), 32'(m_cnt));
      check({tag, ".err"},     32'(key_err), 32'(m_err));
      check({tag, ".sat_cnt"}, 32'(sat_cnt), 32'(m_cnt_sat));
      check({tag, ".sat_bsy"}, 32'(sat_bsy), 32'(model_bsy()));
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later
   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic offer(input logic [6:0] pat, input logic [7:0] key, input logic busy_in);
      best_pat = pat;
      best_key = key;
      best_bsy = busy_in;
   endtask

   task automatic idle(input string tag, input int n);
      offer(7'h00, 8'h00, 1'b0);
      for (int k = 0; k < n; k++) step(tag);
   endtask

   initial begin
      reset = 1'b1;
      cfeb_en = '1; dead_time = '0; hit_thresh = '0; spread_en = 1'b0; cnt_clr = 1'b0;
      offer(7'h00, 8'h00, 1'b0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      compare_all("reset");
      check("reset_bsy_zero", 32'(bsy), 32'h0);
      reset = 1'b0;

      // Basic accept, w = 2, dead time 3
      dead_time = 4'd3; hit_thresh = 3'd3;
      offer(7'h4A, 8'h45, 1'b0);
      step("basic");
      check("basic_vld", 32'(lct_vld), 32'h1);
      check("basic_key", 32'(lct_key), 32'h45);
      check("basic_cnt", 32'(acc_cnt), 32'h1);
      check("basic_bsy1", 32'(bsy), 32'h04);
      offer(7'h00, 8'h00, 1'b0);
      step("basic"); check("basic_bsy2", 32'(bsy), 32'h04);
      step("basic"); check("basic_bsy3", 32'(bsy), 32'h04);
      step("basic"); check("basic_bsy_off", 32'(bsy), 32'h00);

      // Threshold rejects
      offer(7'h2F, 8'h20, 1'b0);
      step("thresh");
      check("thresh_vld", 32'(lct_vld), 32'h0);
      hit_thresh = 3'd0;
      offer(7'h00, 8'h20, 1'b0);
      step("zero_hits");
      check("zero_hits_vld", 32'(lct_vld), 32'h0);

      // Spread at the array edges
      spread_en = 1'b1; dead_time = 4'd2;
      offer(7'h70, 8'hC3, 1'b0);
      step("spread6"); check("spread6_bsy", 32'(bsy), 32'h60);
      idle("spread6", 3);
      offer(7'h70, 8'h01, 1'b0);
      step("spread0"); check("spread0_bsy", 32'(bsy), 32'h03);
      idle("spread0", 3);

      // Reload with a shorter dead time on a running count
      spread_en = 1'b0; dead_time = 4'd5;
      offer(7'h50, 8'h60, 1'b0);
      step("reload");
      idle("reload", 1);
      spread_en = 1'b1; dead_time = 4'd2;
      offer(7'h50, 8'h80, 1'b0);
      step("reload");
      idle("reload", 7);

      // Invalid index, sorter busy, masking
      spread_en = 1'b0; dead_time = 4'd4;
      offer(7'h50, 8'hE0, 1'b0);
      step("keyerr");
      check("keyerr_vld", 32'(lct_vld), 32'h0);
      check("keyerr_flag", 32'(key_err), 32'h1);
      idle("keyerr", 2);
      check("keyerr_sticky", 32'(key_err), 32'h1);
      offer(7'h70, 8'h20, 1'b1);
      step("sorter_bsy");
      check("sorter_bsy_vld", 32'(lct_vld), 32'h0);
      cfeb_en = 7'b1111110;
      idle("mask", 2);
      check("mask_bsy0", 32'(bsy[0]), 32'h1);
      cfeb_en = '1;

      // Asynchronous reset while CFEB 4 is blanked
      dead_time = 4'd6;
      offer(7'h70, 8'h80, 1'b0);
      step("pre_rst");
      check("pre_rst_bsy", 32'(bsy), 32'h10);
      #1 reset = 1'b1;
      #1;
      model_reset();
      check("async_rst_bsy", 32'(bsy), 32'h0);
      check("async_rst_vld", 32'(lct_vld), 32'h0);
      check("async_rst_cnt", 32'(acc_cnt), 32'h0);
      compare_all("async_rst");
      #1 reset = 1'b0;

      // Saturation on the narrow counter, then clear against an accept
      dead_time = 4'd0;
      for (int k = 0; k < 20; k++) begin
         offer(7'h70, 8'(k % 7) << 5, 1'b0);
         step("sat");
      end
      check("sat_hold", 32'(sat_cnt), 32'hF);
      check("sat_wide", 32'(acc_cnt), 32'd20);
      cnt_clr = 1'b1;
      offer(7'h70, 8'h20, 1'b0);
      step("clr");
      check("clr_cnt", 32'(acc_cnt), 32'h0);
      cnt_clr = 1'b0;

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         cfeb_en    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h7F;
         dead_time  = 4'($urandom);
         hit_thresh = 3'($urandom);
         spread_en  = 1'($urandom);
         cnt_clr    = ($urandom_range(0, 39) == 0);
         offer(7'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
